// File: rtl/au_pkg.sv
// Shared types and constants for the add/subtract unit arbiter.
// Mode encodings and the request/response record layouts used around the au block.
package au_pkg;

  localparam int AU_WIDTH = 32;
  localparam int AU_IDW   = 3;

  localparam logic AU_MODE_ADD = 1'b0;
  localparam logic AU_MODE_SUB = 1'b1;

  typedef struct packed {
    logic [AU_WIDTH-1:0] ra;
    logic [AU_WIDTH-1:0] rb;
    logic                mode;
  } au_req_t;

  typedef struct packed {
    logic [AU_IDW-1:0]   id;
    logic [AU_WIDTH-1:0] out;
    logic                ucmp;
    logic                scmp;
  } au_rsp_t;

  // Index following idx in a ring of n entries.
  function automatic logic [AU_IDW-1:0] au_rr_next(input logic [AU_IDW-1:0] idx,
                                                   input int unsigned n);
    logic [AU_IDW-1:0] nxt;
    nxt = idx + AU_IDW'(1);
    if (int'(idx) == int'(n) - 1) nxt = '0;
    return nxt;
  endfunction

endpackage

// File: rtl/au_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req at or after ptr, wrapping.
// Holds no state; the pointer lives in the caller.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any
);

  logic [PW:0] w_cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    w_cand    = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, ptr} + (PW+1)'(k);
      if (w_cand >= (PW+1)'(N)) w_cand = w_cand - (PW+1)'(N);
      for (int i = 0; i < N; i++) begin
        if (enable && !any && req[i] && (w_cand == (PW+1)'(i))) begin
          grant[i]  = 1'b1;
          grant_idx = PW'(i);
          any       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/au_arbiter.sv
// Round-robin sharing of one combinational add/sub unit among NREQ requesters,
// with a one-entry tagged response register. AU_ARB_LOCK_EN adds hold-grant locking.
module au_arbiter
  import au_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_ra,
  input  logic [NREQ*WIDTH-1:0] req_rb,
  input  logic [NREQ-1:0]       req_mode,
  input  logic [NREQ-1:0]       req_lock,
  output logic [WIDTH-1:0]      au_ra,
  output logic [WIDTH-1:0]      au_rb,
  output logic                  au_mode,
  input  logic [WIDTH-1:0]      au_out,
  input  logic                  au_ucmp,
  input  logic                  au_scmp,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_out,
  output logic                  rsp_ucmp,
  output logic                  rsp_scmp
);

  logic [IDW-1:0]   r_ptr;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [WIDTH-1:0] r_rsp_out;
  logic             r_rsp_ucmp;
  logic             r_rsp_scmp;

  logic             w_slot_free;
  logic [NREQ-1:0]  w_req_eff;
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_gidx;
  logic             w_any;
  logic [IDW-1:0]   w_ptr_nxt;
  logic             w_hold_ptr;

  assign w_slot_free = !r_rsp_valid || rsp_ready;
  assign w_ptr_nxt   = (w_gidx == IDW'(NREQ-1)) ? '0 : w_gidx + IDW'(1);

`ifdef AU_ARB_LOCK_EN
  logic           r_lock_active;
  logic [IDW-1:0] r_lock_id;
  logic [NREQ-1:0] w_lock_mask;

  // While locked, the owner is the only eligible requester even when idle.
  assign w_lock_mask = NREQ'(1) << r_lock_id;
  assign w_req_eff   = r_lock_active ? (req_valid & w_lock_mask) : req_valid;
  assign w_hold_ptr  = req_lock[w_gidx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_active <= 1'b0;
      r_lock_id     <= '0;
    end else if (w_any) begin
      if (req_lock[w_gidx]) begin
        r_lock_active <= 1'b1;
        r_lock_id     <= w_gidx;
      end else begin
        r_lock_active <= 1'b0;
      end
    end
  end
`else
  logic w_unused_lock;

  assign w_unused_lock = ^req_lock;
  assign w_req_eff     = req_valid;
  assign w_hold_ptr    = 1'b0;
`endif

  rr_arbiter #(
    .N  (NREQ),
    .PW (IDW)
  ) u_rr (
    .req       (w_req_eff),
    .ptr       (r_ptr),
    .enable    (w_slot_free),
    .grant     (w_grant),
    .grant_idx (w_gidx),
    .any       (w_any)
  );

  assign req_ready = w_grant;

  // Idle unit sees all-zero add operands so it does not toggle.
  always_comb begin
    au_ra   = '0;
    au_rb   = '0;
    au_mode = AU_MODE_ADD;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        au_ra   = au_ra | req_ra[i*WIDTH +: WIDTH];
        au_rb   = au_rb | req_rb[i*WIDTH +: WIDTH];
        au_mode = au_mode | req_mode[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_any && !w_hold_ptr) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // A grant implies the slot is free, so capture also covers drain-and-refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_out   <= '0;
      r_rsp_ucmp  <= 1'b0;
      r_rsp_scmp  <= 1'b0;
    end else if (w_any) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_gidx;
      r_rsp_out   <= au_out;
      r_rsp_ucmp  <= au_ucmp;
      r_rsp_scmp  <= au_scmp;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_out   = r_rsp_out;
  assign rsp_ucmp  = r_rsp_ucmp;
  assign rsp_scmp  = r_rsp_scmp;

endmodule
